// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
// Holds the FSM state encoding and the default channel-tag base.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND_TAG    = 3'd1,
    WAIT_TAG_HI = 3'd2,
    WAIT_TAG_LO = 3'd3,
    SEND_DATA   = 3'd4,
    WAIT_HI     = 3'd5,
    WAIT_LO     = 3'd6
  } arb_state_e;

  localparam logic [7:0] TAG_BASE_DEF = 8'hF0;
  localparam logic [7:0] SBYTE_RST    = 8'hFF;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first requester after index 'last'.
// Purely combinational; 'any' flags a non-empty request vector.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] k;

  // Scan farthest-first so the nearest requester wins.
  always_comb begin
    idx = '0;
    k   = '0;
    for (int i = N; i >= 1; i--) begin
      k = W'((int'(last) + i) % N);
      if (req[k]) idx = k;
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Multi-requester byte arbiter feeding one serial transmitter.
// Optional channel tag before each channel switch: UART_ARB_TAG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_sbyte,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active
);

  localparam int W = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [W-1:0]    grant_q, grant_d;
  logic [W-1:0]    last_q, last_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [7:0]      sbyte_q, sbyte_d;
  logic [W-1:0]    win;
  logic [7:0]      win_byte;
  logic            any;
`ifdef UART_ARB_TAG_EN
  logic [7:0]      data_q, data_d;
  logic [W-1:0]    tag_id_q, tag_id_d;
  logic            tag_vld_q, tag_vld_d;
`endif

  rr_pick #(.N(NREQ), .W(W)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .idx  (win),
    .any  (any)
  );

  assign win_byte = req_data[{win, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ready_d = '0;
    sbyte_d = sbyte_q;
`ifdef UART_ARB_TAG_EN
    data_d    = data_q;
    tag_id_d  = tag_id_q;
    tag_vld_d = tag_vld_q;
`endif
    case (state_q)
      IDLE: if (any) begin
        grant_d = win;
        ready_d = NREQ'(1) << win;
`ifdef UART_ARB_TAG_EN
        data_d = win_byte;
        if (!tag_vld_q || tag_id_q != win) begin
          tag_vld_d = 1'b1;
          tag_id_d  = win;
          sbyte_d   = TAG_BASE + 8'(win);
          state_d   = SEND_TAG;
        end else begin
          sbyte_d = win_byte;
          state_d = SEND_DATA;
        end
`else
        sbyte_d = win_byte;
        state_d = SEND_DATA;
`endif
      end
`ifdef UART_ARB_TAG_EN
      SEND_TAG:    state_d = WAIT_TAG_HI;
      WAIT_TAG_HI: if (tx_busy) state_d = WAIT_TAG_LO;
      WAIT_TAG_LO: if (!tx_busy) begin
        state_d = SEND_DATA;
        sbyte_d = data_q;
      end
`endif
      SEND_DATA: state_d = WAIT_HI;
      WAIT_HI:   if (tx_busy) state_d = WAIT_LO;
      WAIT_LO:   if (!tx_busy) begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= W'(NREQ - 1);
      ready_q <= '0;
      sbyte_q <= SBYTE_RST;
`ifdef UART_ARB_TAG_EN
      data_q    <= '0;
      tag_id_q  <= '0;
      tag_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      sbyte_q <= sbyte_d;
`ifdef UART_ARB_TAG_EN
      data_q    <= data_d;
      tag_id_q  <= tag_id_d;
      tag_vld_q <= tag_vld_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign tx_sbyte  = sbyte_q;
  assign grant_id  = grant_q;
  assign active    = (state_q != IDLE);
`ifdef UART_ARB_TAG_EN
  assign tx_send = (state_q == SEND_DATA) || (state_q == SEND_TAG);
`else
  assign tx_send = (state_q == SEND_DATA);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner
// sequences and random traffic against a byte-stream reference model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_sbyte;
  logic           tx_send;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           active;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_sbyte  (tx_sbyte),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  int ntests = 0;
  int nfail  = 0;

  function automatic void chk(string name, int got, int exp);
    ntests++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Requesters: per-channel byte queues, valid while non-empty.
  logic [7:0] chq [N][$];

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < N; c++) begin
      if (req_ready[c] && chq[c].size() > 0) void'(chq[c].pop_front());
      req_valid[c] = (chq[c].size() > 0);
      req_data[8*c +: 8] = (chq[c].size() > 0) ? chq[c][0] : 8'h00;
    end
  end

  // Transmitter model: busy rises 1-2 cycles after send, lasts 1-4.
  int   bm_ph = 0;
  int   bm_len = 0;
  logic stuck = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      bm_ph   <= 0;
      tx_busy <= 1'b0;
    end else begin
      case (bm_ph)
        0: if (tx_send && !stuck) begin
          bm_len <= $urandom_range(1, 4);
          if ($urandom_range(0, 1) == 1) begin
            tx_busy <= 1'b1;
            bm_ph   <= 2;
          end else begin
            bm_ph <= 1;
          end
        end
        1: begin
          tx_busy <= 1'b1;
          bm_ph   <= 2;
        end
        default: if (bm_len <= 1) begin
          tx_busy <= 1'b0;
          bm_ph   <= 0;
        end else begin
          bm_len <= bm_len - 1;
        end
      endcase
    end
  end

  // Reference model: round-robin by distance from last served.
  function automatic int pick(logic [N-1:0] v, int last);
    int best = -1;
    int bd = N + 1;
    for (int c = 0; c < N; c++) begin
      if (v[c]) begin
        int d = (c - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd = d;
          best = c;
        end
      end
    end
    return best;
  endfunction

  logic [N-1:0]   pv = '0;
  logic [8*N-1:0] pd = '0;
  logic           pa = 1'b0;
  int             last_srv = N - 1;
  int             last_tag = -1;
  int             w_exp, ri;
  int             nready = 0, nsend = 0;
  logic [7:0]     expq[$];
  logic [7:0]     txlog[$];

  always @(negedge clk) begin
    if (reset) begin
      last_srv = N - 1;
      last_tag = -1;
      expq.delete();
      pv = '0;
      pa = 1'b0;
    end else begin
      if (req_ready != '0) begin
        nready++;
        w_exp = pick(pv, last_srv);
        ri = -1;
        for (int c = 0; c < N; c++) if (req_ready[c]) ri = c;
        chk("ready_onehot", $countones(req_ready), 1);
        chk("ready_channel", ri, w_exp);
        chk("grant_id", grant_id, w_exp);
        chk("decide_in_idle", pa, 0);
        chk("send_latency", tx_send, 1);
        if (w_exp >= 0) begin
`ifdef UART_ARB_TAG_EN
          if (w_exp != last_tag) begin
            expq.push_back(TAG_BASE_DEF + 8'(w_exp));
            last_tag = w_exp;
          end
`endif
          expq.push_back(pd[8*w_exp +: 8]);
          last_srv = w_exp;
        end
      end
      if (tx_send) begin
        nsend++;
        txlog.push_back(tx_sbyte);
        chk("send_no_overlap", bm_ph, 0);
        chk("send_expected", (expq.size() > 0) ? 1 : 0, 1);
        if (expq.size() > 0) chk("tx_sbyte", tx_sbyte, expq.pop_front());
      end
      pv = req_valid;
      pd = req_data;
      pa = active;
    end
  end

  task automatic clear_q();
    for (int c = 0; c < N; c++) chq[c].delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_sbyte", tx_sbyte, 8'hFF);
    chk("rst_grant", grant_id, 0);
    chk("rst_active", active, 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < N; c++) s += chq[c].size();
    return s;
  endfunction

  task automatic wait_idle(int budget);
    int k = 0;
    @(negedge clk);
    while ((active || pending() > 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_budget", (k < budget) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_busy(int budget);
    int k = 0;
    while (!tx_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("busy_seen", tx_busy, 1);
  endtask

  task automatic cmp_log(string name, logic [7:0] exp[$]);
    chk({name, "_len"}, txlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < txlog.size(); i++)
      chk(name, txlog[i], exp[i]);
  endtask

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         exp_grant;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] exps[$];
  int         k, s0, r0, npush;
  logic       fell;

  initial begin
    tbl[0] = '{0, 8'h41, 0};
    tbl[1] = '{2, 8'h5A, 2};
    tbl[2] = '{2, 8'h33, 2};
    tbl[3] = '{1, 8'h77, 1};
    tbl[4] = '{3, 8'hC4, 3};
    tbl[5] = '{0, 8'h00, 0};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      chq[tbl[i].ch].push_back(tbl[i].data);
      wait_idle(60);
      chk("tbl_grant", grant_id, tbl[i].exp_grant);
      chk("tbl_sbyte_hold", tx_sbyte, tbl[i].data);
      chk("tbl_idle", active, 0);
    end

    // All four valid: strict rotation, channel 0 again last.
    do_reset();
    txlog.delete();
    chq[0].push_back(8'h10);
    chq[0].push_back(8'h10);
    chq[1].push_back(8'h11);
    chq[2].push_back(8'h12);
    chq[3].push_back(8'h13);
    wait_idle(200);
    exps.delete();
    for (int i = 0; i < 5; i++) begin
`ifdef UART_ARB_TAG_EN
      exps.push_back(8'hF0 + 8'(i % 4));
`endif
      exps.push_back(8'h10 + 8'(i % 4));
    end
    cmp_log("rotation", exps);

    // ch1 arrives while ch2 frame is still busy.
    chq[2].push_back(8'h62);
    @(negedge clk);
    wait_busy(20);
    chq[1].push_back(8'h61);
    fell = 1'b0;
    k = 0;
    while (!req_ready[1] && k < 40) begin
      @(negedge clk);
      if (!tx_busy) fell = 1'b1;
      k++;
    end
    chk("ch1_granted", req_ready[1], 1);
    chk("ch1_after_busy_fall", fell, 1);
    wait_idle(60);

`ifdef UART_ARB_TAG_EN
    do_reset();
    txlog.delete();
    chq[3].push_back(8'h55);
    chq[3].push_back(8'h55);
    wait_idle(100);
    chq[0].push_back(8'hAA);
    wait_idle(100);
    exps = '{8'hF3, 8'h55, 8'h55, 8'hF0, 8'hAA};
    cmp_log("tag_seq", exps);
`endif

    // Reset in the middle of a frame.
    do_reset();
    chq[0].push_back(8'h01);
    wait_idle(60);
    chq[1].push_back(8'h02);
    @(negedge clk);
    wait_busy(20);
    reset = 1'b1;
    clear_q();
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_active", active, 0);
    chk("midrst_send", tx_send, 0);
    txlog.delete();
    chq[0].push_back(8'h03);
    chq[2].push_back(8'h04);
    k = 0;
    while (req_ready == '0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_first_grant", grant_id, 0);
    wait_idle(100);
    exps.delete();
`ifdef UART_ARB_TAG_EN
    exps.push_back(8'hF0);
`endif
    exps.push_back(8'h03);
`ifdef UART_ARB_TAG_EN
    exps.push_back(8'hF2);
`endif
    exps.push_back(8'h04);
    cmp_log("midrst_seq", exps);

    // Transmitter never raises busy.
    do_reset();
    stuck = 1'b1;
    s0 = nsend;
    r0 = nready;
    chq[0].push_back(8'h77);
    repeat (5) @(negedge clk);
    chq[1].push_back(8'h78);
    repeat (20) @(negedge clk);
    chk("stuck_active", active, 1);
    chk("stuck_sends", nsend - s0, 1);
    chk("stuck_readies", nready - r0, 1);
    stuck = 1'b0;

    // Random traffic.
    do_reset();
    r0 = nready;
    npush = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, N - 1);
        if (chq[k].size() < 3) begin
          chq[k].push_back(8'($urandom));
          npush++;
        end
      end
    end
    wait_idle(3000);
    chk("rand_all_granted", nready - r0, npush);
    chk("rand_all_sent", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
